// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Two-port arbiter and access sequencer in front of the
//            byte-addressed data memory. Port 0 is the CPU load/store stage,
//            port 1 is the loader/debug master. Requests are serialised,
//            bounds-checked before any strobe is raised, and issued as clean
//            one-access strobe windows separated by a strobe-low gap.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            reqN_*_i              request (valid/we/size/addr/wdata)
//            reqN_ready_o          request accepted this cycle
//            rspN_*_o              one-cycle response pulse, rdata, exc
//            mem_*_o / mem_rdata_i memory strobes, address, data
//            busy_o                sequencer not idle
//            stat_*_o              grant/fault counters (DMEM_ARB_STATS_EN only)
// Options  : `define DMEM_ARB_STATS_EN adds saturating 32-bit statistics.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int NUM_DATA      = 90,
    parameter int ACCESS_CYCLES = 2,
    parameter int CPU_PRIORITY  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid_i,
    input  logic        req0_we_i,
    input  logic [1:0]  req0_size_i,
    input  logic [63:0] req0_addr_i,
    input  logic [63:0] req0_wdata_i,
    input  logic        req1_valid_i,
    input  logic        req1_we_i,
    input  logic [1:0]  req1_size_i,
    input  logic [63:0] req1_addr_i,
    input  logic [63:0] req1_wdata_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    output logic        rsp0_valid_o,
    output logic [63:0] rsp0_rdata_o,
    output logic [1:0]  rsp0_exc_o,
    output logic        rsp1_valid_o,
    output logic [63:0] rsp1_rdata_o,
    output logic [1:0]  rsp1_exc_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic [1:0]  mem_size_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0] stat_grant0_o,
    output logic [31:0] stat_grant1_o,
    output logic [31:0] stat_fault_o,
`endif
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ACCESS = 3'd2,
        S_GAP    = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    localparam logic [3:0]  C_CNT_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [64:0] C_LIMIT    = 65'(NUM_DATA);

    state_e      state_q, state_d;
    logic        prio_q, prio_d;          // port that wins the next tie
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  exc_q, exc_d;

    logic        w_gnt0, w_gnt1;
    logic [3:0]  w_nbytes;
    logic [63:0] w_mask;
    logic [64:0] w_end;
    logic        w_fault;

    // Grants are only issued from IDLE; ready is held low while in reset
    // so that no output toggles before the block is released.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n && (state_q == S_IDLE)) begin
            if (req0_valid_i && req1_valid_i) begin
                if ((CPU_PRIORITY != 0) || !prio_q) w_gnt0 = 1'b1;
                else                                w_gnt1 = 1'b1;
            end else if (req0_valid_i) begin
                w_gnt0 = 1'b1;
            end else if (req1_valid_i) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   begin w_nbytes = 4'd4; w_mask = 64'h0000_0000_FFFF_FFFF; end
            2'b01:   begin w_nbytes = 4'd2; w_mask = 64'h0000_0000_0000_FFFF; end
            2'b10:   begin w_nbytes = 4'd1; w_mask = 64'h0000_0000_0000_00FF; end
            default: begin w_nbytes = 4'd8; w_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
    end

    // 65-bit end address so that addresses near 2^64 cannot wrap into range.
    assign w_end   = {1'b0, addr_q} + 65'(w_nbytes);
    assign w_fault = addr_q[63] || (w_end > C_LIMIT);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        port_d  = port_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        case (state_q)
            S_IDLE: begin
                if (w_gnt0 || w_gnt1) begin
                    port_d  = w_gnt1;
                    prio_d  = w_gnt0;
                    we_d    = w_gnt1 ? req1_we_i    : req0_we_i;
                    size_d  = w_gnt1 ? req1_size_i  : req0_size_i;
                    addr_d  = w_gnt1 ? req1_addr_i  : req0_addr_i;
                    wdata_d = w_gnt1 ? req1_wdata_i : req0_wdata_i;
                    rdata_d = 64'd0;
                    exc_d   = 2'b00;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_fault) begin
                    exc_d   = we_q ? 2'b01 : 2'b10;
                    rdata_d = 64'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = C_CNT_LOAD;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) rdata_d = mem_rdata_i & w_mask;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            exc_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            port_q  <= port_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    // Strobes decode directly from the state register so an asynchronous
    // reset removes them immediately.
    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;
    assign busy_o       = (state_q != S_IDLE);
    assign mem_write_o  = (state_q == S_ACCESS) &&  we_q;
    assign mem_read_o   = (state_q == S_ACCESS) && !we_q;
    assign mem_size_o   = size_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign rsp0_valid_o = (state_q == S_RESP) && !port_q;
    assign rsp1_valid_o = (state_q == S_RESP) &&  port_q;
    assign rsp0_rdata_o = rsp0_valid_o ? rdata_q : 64'd0;
    assign rsp1_rdata_o = rsp1_valid_o ? rdata_q : 64'd0;
    assign rsp0_exc_o   = rsp0_valid_o ? exc_q : 2'b00;
    assign rsp1_exc_o   = rsp1_valid_o ? exc_q : 2'b00;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_grant0_q, stat_grant1_q, stat_fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0_q <= 32'd0;
            stat_grant1_q <= 32'd0;
            stat_fault_q  <= 32'd0;
        end else begin
            if (w_gnt0 && (stat_grant0_q != 32'hFFFF_FFFF)) stat_grant0_q <= stat_grant0_q + 32'd1;
            if (w_gnt1 && (stat_grant1_q != 32'hFFFF_FFFF)) stat_grant1_q <= stat_grant1_q + 32'd1;
            if ((state_q == S_CHECK) && w_fault && (stat_fault_q != 32'hFFFF_FFFF))
                stat_fault_q <= stat_fault_q + 32'd1;
        end
    end

    assign stat_grant0_o = stat_grant0_q;
    assign stat_grant1_o = stat_grant1_q;
    assign stat_fault_o  = stat_fault_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Self-checking bench for data_mem_arbiter: directed scenarios
//            followed by random requests, checked against a byte-array
//            reference memory and latency/strobe rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int NUM_DATA = 90;
    localparam int AC       = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        r0v, r0we, r1v, r1we;
    logic [1:0]  r0sz, r1sz;
    logic [63:0] r0a, r0wd, r1a, r1wd;
    logic        r0rdy, r1rdy, s0v, s1v;
    logic [63:0] s0rd, s1rd;
    logic [1:0]  s0exc, s1exc;
    logic        mwr, mrd, busy;
    logic [1:0]  msz;
    logic [63:0] maddr, mwd, mrdata;

    data_mem_arbiter #(.NUM_DATA(NUM_DATA), .ACCESS_CYCLES(AC), .CPU_PRIORITY(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(r0v), .req0_we_i(r0we), .req0_size_i(r0sz), .req0_addr_i(r0a), .req0_wdata_i(r0wd),
        .req1_valid_i(r1v), .req1_we_i(r1we), .req1_size_i(r1sz), .req1_addr_i(r1a), .req1_wdata_i(r1wd),
        .req0_ready_o(r0rdy), .req1_ready_o(r1rdy),
        .rsp0_valid_o(s0v), .rsp0_rdata_o(s0rd), .rsp0_exc_o(s0exc),
        .rsp1_valid_o(s1v), .rsp1_rdata_o(s1rd), .rsp1_exc_o(s1exc),
        .mem_write_o(mwr), .mem_read_o(mrd), .mem_size_o(msz), .mem_addr_o(maddr),
        .mem_wdata_o(mwd), .mem_rdata_i(mrdata), .busy_o(busy)
    );

    // Second instance with fixed CPU priority, used only for grant order.
    logic        pv0, pv1, pr0, pr1, ps0v, ps1v, pwr, prd, pbusy;
    logic [63:0] ps0rd, ps1rd, paddr, pwd;
    logic [1:0]  ps0exc, ps1exc, psz;

    data_mem_arbiter #(.NUM_DATA(NUM_DATA), .ACCESS_CYCLES(AC), .CPU_PRIORITY(1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(pv0), .req0_we_i(1'b0), .req0_size_i(2'b10), .req0_addr_i(64'd3), .req0_wdata_i(64'd0),
        .req1_valid_i(pv1), .req1_we_i(1'b0), .req1_size_i(2'b10), .req1_addr_i(64'd4), .req1_wdata_i(64'd0),
        .req0_ready_o(pr0), .req1_ready_o(pr1),
        .rsp0_valid_o(ps0v), .rsp0_rdata_o(ps0rd), .rsp0_exc_o(ps0exc),
        .rsp1_valid_o(ps1v), .rsp1_rdata_o(ps1rd), .rsp1_exc_o(ps1exc),
        .mem_write_o(pwr), .mem_read_o(prd), .mem_size_o(psz), .mem_addr_o(paddr),
        .mem_wdata_o(pwd), .mem_rdata_i(64'd0), .busy_o(pbusy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nb_of(input logic [1:0] s);
        case (s)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 8;
        endcase
    endfunction

    // Memory seen by the DUT, little-endian, returns all 8 bytes raw.
    logic [7:0] mem [0:NUM_DATA-1];
    logic       mem_fill;
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < NUM_DATA; i++) mem[i] <= 8'((i * 37 + 11) & 255);
        end else if (mwr) begin
            for (int k = 0; k < 8; k++)
                if (k < nb_of(msz) && (maddr + 64'(k)) < 64'(NUM_DATA))
                    mem[7'(maddr + 64'(k))] <= mwd[8*k +: 8];
        end
    end

    always_comb begin
        logic [63:0] a;
        mrdata = 64'd0;
        for (int k = 0; k < 8; k++) begin
            a = maddr + 64'(k);
            if (a < 64'(NUM_DATA)) mrdata[8*k +: 8] = mem[a[6:0]];
        end
    end

    // Passive monitor counters, sampled mid-cycle.
    int   wr_cyc = 0, rd_cyc = 0, rises = 0, rsp_cnt0 = 0, rsp_cnt1 = 0, both_rdy = 0, addr_unstable = 0;
    logic prev_strb = 1'b0;
    logic [63:0] prev_addr = 64'd0;
    always @(negedge clk) begin
        if (mwr) wr_cyc++;
        if (mrd) rd_cyc++;
        if ((mwr || mrd) && !prev_strb) rises++;
        if ((mwr || mrd) && prev_strb && (maddr !== prev_addr)) addr_unstable++;
        if (s0v) rsp_cnt0++;
        if (s1v) rsp_cnt1++;
        if (r0rdy && r1rdy) both_rdy++;
        prev_strb = mwr || mrd;
        prev_addr = maddr;
    end

    // Reference model state.
    logic [7:0] ref_mem [0:NUM_DATA-1];
    int         tie_next;     // port expected to win the next tie
    int         n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic we, input logic [1:0] sz,
                           input logic [63:0] a, input logic [63:0] wd);
        if (p == 0) begin r0v = v; r0we = we; r0sz = sz; r0a = a; r0wd = wd; end
        else        begin r1v = v; r1we = we; r1sz = sz; r1a = a; r1wd = wd; end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] a, input int nb);
        logic [63:0] d;
        d = 64'd0;
        for (int k = 0; k < nb; k++) d[8*k +: 8] = ref_mem[7'(a + 64'(k))];
        return d;
    endfunction

    task automatic do_req(input int p, input logic we, input logic [1:0] sz,
                          input logic [63:0] a, input logic [63:0] wd);
        int nb, n, t_g, t_r, wr0, rd0, rs0, q0, q1;
        bit fault, got;
        logic [63:0] exp_rd, obs_rd;
        logic [1:0]  exp_exc, obs_exc;
        nb      = nb_of(sz);
        fault   = a[63] || (a > 64'(NUM_DATA - nb));
        exp_rd  = (!we && !fault) ? ref_load(a, nb) : 64'd0;
        exp_exc = fault ? (we ? 2'b01 : 2'b10) : 2'b00;
        t_g = 0; t_r = 0; obs_rd = 64'd0; obs_exc = 2'b00;
        @(posedge clk); #1;
        set_req(p, 1'b1, we, sz, a, wd);
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if ((p == 0) ? r0rdy : r1rdy) begin got = 1; t_g = cyc; tie_next = 1 - p; end
        end
        check("grant", 64'(got), 64'd1);
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        wr0 = wr_cyc; rd0 = rd_cyc; rs0 = rises; q0 = rsp_cnt0; q1 = rsp_cnt1;
        got = 0; n = 0;
        while (!got && n < 30) begin
            @(negedge clk); n++;
            if ((p == 0) ? s0v : s1v) begin
                got = 1; t_r = cyc;
                obs_rd  = (p == 0) ? s0rd : s1rd;
                obs_exc = (p == 0) ? s0exc : s1exc;
            end
        end
        check("rsp_seen", 64'(got), 64'd1);
        check("latency", 64'(t_r - t_g), fault ? 64'd2 : 64'(3 + AC));
        check("rdata", obs_rd, exp_rd);
        check("exc", 64'(obs_exc), 64'(exp_exc));
        @(posedge clk); #1;
        check("write_cycles", 64'(wr_cyc - wr0), (!fault && we) ? 64'(AC) : 64'd0);
        check("read_cycles", 64'(rd_cyc - rd0), (!fault && !we) ? 64'(AC) : 64'd0);
        check("strobe_edges", 64'(rises - rs0), fault ? 64'd0 : 64'd1);
        check("rsp_own_count", 64'((p == 0) ? (rsp_cnt0 - q0) : (rsp_cnt1 - q1)), 64'd1);
        check("rsp_other_count", 64'((p == 0) ? (rsp_cnt1 - q1) : (rsp_cnt0 - q0)), 64'd0);
        if (we && !fault)
            for (int k = 0; k < nb; k++) ref_mem[7'(a + 64'(k))] = wd[8*k +: 8];
    endtask

    initial begin
        int g, n, w, last_t, grants, rsps, t_first;
        int rs0, rd0, q0, sel;
        logic [1:0]  sz;
        logic [63:0] a, exp_w, d0, d1;

        rst_n = 1'b0; mem_fill = 1'b1; pv0 = 1'b0; pv1 = 1'b0;
        set_req(0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        set_req(1, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        for (int i = 0; i < NUM_DATA; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
        tie_next = 0;
        repeat (3) @(posedge clk);
        #1 mem_fill = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_strobes", 64'({mwr, mrd}), 64'd0);
        check("reset_rsp", 64'({s0v, s1v}), 64'd0);
        check("reset_ready", 64'({r0rdy, r1rdy}), 64'd0);
        check("reset_addr", maddr, 64'd0);

        // Double store then load back on port 0.
        do_req(0, 1'b1, 2'b11, 64'h10, 64'h1122334455667788);
        do_req(0, 1'b0, 2'b11, 64'h10, 64'd0);
        check("store_load_value", ref_load(64'h10, 8), 64'h1122334455667788);

        // Bounds on port 1.
        do_req(1, 1'b0, 2'b10, 64'd89, 64'd0);
        do_req(1, 1'b0, 2'b00, 64'd86, 64'd0);
        do_req(1, 1'b0, 2'b00, 64'd87, 64'd0);
        do_req(0, 1'b1, 2'b01, 64'h8000000000000000, 64'hABCD);
        do_req(1, 1'b1, 2'b01, 64'd88, 64'h5A5A);
        do_req(1, 1'b1, 2'b01, 64'd89, 64'h5A5A);

        // Back-to-back loads from port 0 to the same address.
        exp_w = ref_load(64'h20, 4);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 2'b00, 64'h20, 64'd0);
        grants = 0; rsps = 0; n = 0; t_first = 0; d0 = 64'd0; d1 = 64'd0;
        rs0 = rises; rd0 = rd_cyc;
        while (rsps < 2 && n < 40) begin
            @(negedge clk); n++;
            if (r0rdy) begin
                if (grants == 0) t_first = cyc;
                else check("b2b_grant_spacing", 64'(cyc - t_first), 64'(4 + AC));
                grants++; tie_next = 1;
            end
            if (s0v) begin
                if (rsps == 0) d0 = s0rd; else d1 = s0rd;
                rsps++;
            end
            if (grants == 2 && r0v) begin @(posedge clk); #1; r0v = 1'b0; end
        end
        @(posedge clk); #1;
        check("b2b_responses", 64'(rsps), 64'd2);
        check("b2b_read_edges", 64'(rises - rs0), 64'd2);
        check("b2b_read_cycles", 64'(rd_cyc - rd0), 64'(2 * AC));
        check("b2b_data0", d0, exp_w);
        check("b2b_data1", d1, exp_w);

        // Round-robin with both ports valid continuously.
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 2'b10, 64'd5, 64'd0);
        set_req(1, 1'b1, 1'b0, 2'b10, 64'd6, 64'd0);
        g = 0; n = 0; last_t = 0;
        while (g < 4 && n < 60) begin
            @(negedge clk); n++;
            if (r0rdy || r1rdy) begin
                check("arb_one_hot", 64'(r0rdy && r1rdy), 64'd0);
                w = r1rdy ? 1 : 0;
                check("arb_rr_winner", 64'(w), 64'(tie_next));
                if (g > 0) check("arb_spacing", 64'(cyc - last_t), 64'(4 + AC));
                tie_next = 1 - w; last_t = cyc; g++;
                if (g == 4) begin @(posedge clk); #1; r0v = 1'b0; r1v = 1'b0; end
            end
        end
        check("arb_grants", 64'(g), 64'd4);
        repeat (AC + 6) @(posedge clk);

        // Fixed CPU priority instance.
        #1 pv0 = 1'b1; pv1 = 1'b1;
        g = 0; n = 0;
        while (g < 4 && n < 60) begin
            @(negedge clk); n++;
            if (pr0 || pr1) begin
                check("prio_winner", 64'(pr1), 64'd0);
                g++;
                if (g == 4) begin @(posedge clk); #1; pv0 = 1'b0; pv1 = 1'b0; end
            end
        end
        check("prio_grants", 64'(g), 64'd4);
        repeat (AC + 6) @(posedge clk);

        // Reset in the middle of an access window.
        #1 set_req(0, 1'b1, 1'b0, 2'b11, 64'h10, 64'd0);
        n = 0;
        while (!mrd && n < 20) begin @(negedge clk); n++; end
        check("abort_read_seen", 64'(mrd), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_strobes", 64'({mwr, mrd}), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(r0rdy), 64'd0);
        set_req(0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        q0 = rsp_cnt0 + rsp_cnt1;
        @(posedge clk); #1 rst_n = 1'b1;
        tie_next = 0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_rsp", 64'(rsp_cnt0 + rsp_cnt1 - q0), 64'd0);
        do_req(0, 1'b0, 2'b11, 64'h10, 64'd0);

        // Random requests.
        for (int i = 0; i < 24; i++) begin
            sz  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 64'($urandom_range(0, NUM_DATA + 4));
                1:       a = 64'(NUM_DATA - nb_of(sz) + $urandom_range(0, 1));
                2:       a = {1'b1, 31'($urandom), 32'($urandom)};
                default: a = 64'($urandom_range(0, NUM_DATA - 8));
            endcase
            do_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom});
        end

        check("never_both_ready", 64'(both_rdy), 64'd0);
        check("addr_stable_in_window", 64'(addr_unstable), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
